rf_bist: RTL and testbench
==========================

RF_BIST -- requirements
Module: rf_bist

Interface
REQ-001 CLK  in  1  system clock; all state changes on rising edge.
REQ-002 nRST  in  1  asynchronous, active-low reset.
REQ-003 start  in  1  level-sampled request to run the test; honoured only in IDLE or DONE.
REQ-004 busy  out  1  high in WRITE and READ states.
REQ-005 done  out  1  high in DONE state; held until the next accepted start.
REQ-006 pass  out  1  valid while done=1; 1 = no mismatch found.
REQ-007 fail_addr  out  5  register address of the first mismatch; 0 when pass=1.
REQ-008 WEN  out  1  register-file write enable.
REQ-009 wsel  out  5  register-file write address.
REQ-010 wdat  out  32  register-file write data.
REQ-011 rsel1, rsel2  out  5 each  register-file read addresses.
REQ-012 rdat1, rdat2  in  32 each  register-file read data; combinational from rsel in the same cycle.

Function
REQ-013 FSM states are IDLE, WRITE, READ and DONE; the module also holds a 5-bit counter cnt and a phase bit ph.
REQ-014 Pattern: pat(a,0) = 32'hA5A5_0000 | a (zero-extended); pat(a,1) = ~pat(a,0).
REQ-015 Expected read value: exp(a,ph) = 0 when a=0; otherwise pat(a,ph).
REQ-016 IDLE or DONE with start=1 -> WRITE with cnt=0, ph=0, done=0, pass=0, fail_addr=0.
REQ-017 WRITE: WEN=1, wsel=cnt, wdat=pat(cnt,ph).
REQ-018 WRITE: cnt increments each cycle; the cycle with cnt=31 -> READ with cnt=0.
REQ-019 Address 0 is also written with a non-zero pattern, to prove that register 0 ignores writes.
REQ-020 READ: WEN=0, rsel1=cnt, rsel2=31-cnt (5-bit).
REQ-021 READ: the same cycle compares rdat1 with exp(cnt,ph) and rdat2 with exp(31-cnt,ph).
REQ-022 READ on a mismatch -> DONE with pass=0.
REQ-023 On a mismatch, fail_addr = cnt if the port-1 comparison failed, else 31-cnt; port 1 has priority when both fail.
REQ-024 READ with no mismatch and cnt=31: if ph=0 -> WRITE with cnt=0 and ph=1.
REQ-025 READ with no mismatch and cnt=31: if ph=1 -> DONE with pass=1 and fail_addr=0.
REQ-026 With no failure, a run is 128 busy cycles (WRITE, READ, WRITE, READ, 32 cycles each).
REQ-027 With no failure, busy is high for edges k+1..k+128 after start is sampled at edge k; done is first high after edge k+129.
REQ-028 start while busy is ignored; the run continues unchanged.
REQ-029 start held high in DONE restarts immediately; done drops one cycle later.
REQ-030 Outside WRITE: WEN=0, wsel=0, wdat=0; outside READ: rsel1=0, rsel2=0.
REQ-031 cnt wraps only via state transitions; cnt never advances in IDLE or DONE.

Reset
REQ-032 nRST=0 forces IDLE, cnt=0 and ph=0 immediately, independent of CLK.
REQ-033 nRST=0 drives busy=0, done=0, pass=0, fail_addr=0, WEN=0, wsel=0, wdat=0, rsel1=0, rsel2=0.
REQ-034 Reset mid-run aborts the test; no partial result is retained, and a new start is required after release.

Verification
REQ-035 Good register file, start pulse -> WEN high 32 cycles, then rsel1 0..31 / rsel2 31..0, repeated once; done=1, pass=1, fail_addr=0 after 129 edges.
REQ-036 Bit 3 of register 12 stuck-at-0 -> done=1, pass=0, fail_addr=12 during phase-0 READ; second WRITE never issued.
REQ-037 Register file that allows writes to register 0 (rdat=32'hA5A5_0000) -> pass=0, fail_addr=0 on the first READ cycle.
REQ-038 Port-2-only fault on register 5 -> pass=0, fail_addr=5, detected at READ cnt=26.
REQ-039 nRST asserted at cycle 40 of a run -> all outputs zero at once; after release with no start, the module stays idle with done=0.
REQ-040 start toggled during a run -> completion time and result identical to REQ-035; start held high in DONE starts a second run.

Source files
------------

// File: rtl/rf_bist.sv
// Register-file BIST: writes a/~a patterns to all 32 registers, reads both ports back, reports the first mismatch.
// Latency: start is registered, WRITE begins one cycle later; a clean run is 128 busy cycles then DONE.
// Backpressure: none; start is ignored while busy and results hold in DONE until the next accepted start.
module rf_bist (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic [4:0]  fail_addr,
  output logic        WEN,
  output logic [4:0]  wsel,
  output logic [31:0] wdat,
  output logic [4:0]  rsel1,
  output logic [4:0]  rsel2,
  input  logic [31:0] rdat1,
  input  logic [31:0] rdat2
);

  typedef enum logic [1:0] {IDLE, WRITE, READ, DONE} state_t;

  state_t      state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic        ph_q, ph_d;
  logic        start_q, start_d;
  logic        pass_q, pass_d;
  logic [4:0]  fail_addr_q, fail_addr_d;

  logic [4:0]  idx2;
  logic        mis1, mis2;

  function automatic logic [31:0] pat(input logic [4:0] a, input logic p);
    logic [31:0] v;
    v = 32'hA5A5_0000 | {27'd0, a};
    return p ? ~v : v;
  endfunction

  // Register 0 is hardwired to zero, so it must read back 0 whatever was written.
  function automatic logic [31:0] exp_val(input logic [4:0] a, input logic p);
    return (a == 5'd0) ? 32'd0 : pat(a, p);
  endfunction

  assign idx2 = 5'd31 - cnt_q;
  assign mis1 = (rdat1 != exp_val(cnt_q, ph_q));
  assign mis2 = (rdat2 != exp_val(idx2, ph_q));

  // Next-state logic: start capture, sequencing through both phases, mismatch capture.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    ph_d        = ph_q;
    pass_d      = pass_q;
    fail_addr_d = fail_addr_q;
    // Only a start seen while idle or done can launch a run; starts during a run are dropped.
    start_d     = start && ((state_q == IDLE) || (state_q == DONE));
    case (state_q)
      IDLE, DONE: begin
        if (start_q) begin
          state_d     = WRITE;
          cnt_d       = 5'd0;
          ph_d        = 1'b0;
          pass_d      = 1'b0;
          fail_addr_d = 5'd0;
        end
      end
      WRITE: begin
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == 5'd31) begin
          state_d = READ;
        end
      end
      READ: begin
        if (mis1 || mis2) begin
          state_d     = DONE;
          cnt_d       = 5'd0;
          pass_d      = 1'b0;
          fail_addr_d = mis1 ? cnt_q : idx2;
        end else begin
          cnt_d = cnt_q + 5'd1;
          if (cnt_q == 5'd31) begin
            if (!ph_q) begin
              state_d = WRITE;
              ph_d    = 1'b1;
            end else begin
              state_d     = DONE;
              pass_d      = 1'b1;
              fail_addr_d = 5'd0;
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q     <= IDLE;
      cnt_q       <= 5'd0;
      ph_q        <= 1'b0;
      start_q     <= 1'b0;
      pass_q      <= 1'b0;
      fail_addr_q <= 5'd0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      ph_q        <= ph_d;
      start_q     <= start_d;
      pass_q      <= pass_d;
      fail_addr_q <= fail_addr_d;
    end
  end

  // Outputs decoded purely from registered state so they are glitch-free and zero outside their state.
  always_comb begin
    busy      = (state_q == WRITE) || (state_q == READ);
    done      = (state_q == DONE);
    pass      = (state_q == DONE) && pass_q;
    fail_addr = (state_q == DONE) ? fail_addr_q : 5'd0;
    WEN       = (state_q == WRITE);
    wsel      = (state_q == WRITE) ? cnt_q : 5'd0;
    wdat      = (state_q == WRITE) ? pat(cnt_q, ph_q) : 32'd0;
    rsel1     = (state_q == READ) ? cnt_q : 5'd0;
    rsel2     = (state_q == READ) ? idx2 : 5'd0;
  end

endmodule

// File: tb/tb_rf_bist.sv
// Bench for rf_bist: behavioural register file with selectable faults, table of runs, scoreboard of results.
// Latency is measured in clock edges from the edge that samples start.
// Also covers mid-run reset and start held high in DONE.
module tb_rf_bist;

  logic        CLK;
  logic        nRST;
  logic        start;
  logic        busy, done, pass, WEN;
  logic [4:0]  fail_addr, wsel, rsel1, rsel2;
  logic [31:0] wdat, rdat1, rdat2;

  int checks = 0;
  int errors = 0;
  int mode   = 0;   // 0 good, 1 reg12 bit3 stuck-0, 2 reg0 writable, 3 port-2 fault on reg5

  logic [31:0] rf [32];

  rf_bist dut (
    .CLK(CLK), .nRST(nRST), .start(start),
    .busy(busy), .done(done), .pass(pass), .fail_addr(fail_addr),
    .WEN(WEN), .wsel(wsel), .wdat(wdat),
    .rsel1(rsel1), .rsel2(rsel2), .rdat1(rdat1), .rdat2(rdat2)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  // Register file model; register 0 ignores writes unless the reg0 fault is selected.
  always_ff @(posedge CLK) begin
    if (WEN && ((wsel != 5'd0) || (mode == 2))) rf[wsel] <= wdat;
  end

  always_comb begin
    rdat1 = rf[rsel1];
    if (rsel1 == 5'd0 && mode != 2) rdat1 = 32'd0;
    if (mode == 1 && rsel1 == 5'd12) rdat1[3] = 1'b0;
    rdat2 = rf[rsel2];
    if (rsel2 == 5'd0 && mode != 2) rdat2 = 32'd0;
    if (mode == 1 && rsel2 == 5'd12) rdat2[3] = 1'b0;
    if (mode == 3 && rsel2 == 5'd5) rdat2[0] = ~rdat2[0];
  end

  typedef struct {
    int         mode;
    bit         toggle;
    bit         exp_pass;
    logic [4:0] exp_fa;
    int         exp_lat;
    int         exp_wen;
    int         exp_busy;
  } vec_t;

  vec_t vecs[5];
  vec_t sb[$];
  logic [31:0] w7[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, expv);
    end
  endtask

  task automatic outs_zero(input string p);
    chk({p, "_busy"},  32'(busy),      32'd0);
    chk({p, "_done"},  32'(done),      32'd0);
    chk({p, "_pass"},  32'(pass),      32'd0);
    chk({p, "_faddr"}, 32'(fail_addr), 32'd0);
    chk({p, "_wen"},   32'(WEN),       32'd0);
    chk({p, "_wsel"},  32'(wsel),      32'd0);
    chk({p, "_wdat"},  wdat,           32'd0);
    chk({p, "_rsel1"}, 32'(rsel1),     32'd0);
    chk({p, "_rsel2"}, 32'(rsel2),     32'd0);
  endtask

  task automatic do_reset(input int m);
    @(negedge CLK);
    nRST = 1'b0;
    mode = m;
    @(negedge CLK);
    nRST = 1'b1;
  endtask

  initial begin
    int n, lat, wen_cnt, busy_cnt, rsel_err, first_done, first_busy;
    bit got;
    logic [4:0] rd_idx;
    vec_t e;

    //          mode tog pass fa  lat  wen busy
    vecs[0] = '{0,   0,  1,   0,  129, 64, 128};
    vecs[1] = '{1,   0,  0,   12, 46,  32, 45};
    vecs[2] = '{2,   0,  0,   0,  34,  32, 33};
    vecs[3] = '{3,   0,  0,   5,  60,  32, 59};
    vecs[4] = '{0,   1,  1,   0,  129, 64, 128};

    nRST  = 1'b0;
    start = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    outs_zero("reset");
    @(negedge CLK);
    nRST = 1'b1;

    for (int i = 0; i < 5; i++) begin
      do_reset(vecs[i].mode);
      w7.delete();
      @(negedge CLK);
      start = 1'b1;
      sb.push_back(vecs[i]);
      n = 0; got = 0; lat = 0; wen_cnt = 0; busy_cnt = 0; rsel_err = 0; rd_idx = 5'd0;
      while (!got && n < 400) begin
        @(posedge CLK);
        #1;
        n++;
        start = (vecs[i].toggle && n < 100) ? ~start : 1'b0;
        if (WEN) wen_cnt++;
        if (WEN && wsel == 5'd7) w7.push_back(wdat);
        if (busy) busy_cnt++;
        if (busy && !WEN) begin
          if (rsel1 != rd_idx || rsel2 != (5'd31 - rd_idx)) rsel_err++;
          rd_idx = rd_idx + 5'd1;
        end
        if (done) begin
          got = 1;
          lat = n - 1;
        end
      end
      start = 1'b0;
      e = sb.pop_front();
      if (!got) begin
        chk($sformatf("v%0d_done_timeout", i), 32'(got), 32'd1);
      end else begin
        chk($sformatf("v%0d_pass", i),  32'(pass),      32'(e.exp_pass));
        chk($sformatf("v%0d_faddr", i), 32'(fail_addr), 32'(e.exp_fa));
        chk($sformatf("v%0d_lat", i),   32'(lat),       32'(e.exp_lat));
        chk($sformatf("v%0d_wen", i),   32'(wen_cnt),   32'(e.exp_wen));
        chk($sformatf("v%0d_busy", i),  32'(busy_cnt),  32'(e.exp_busy));
        chk($sformatf("v%0d_rsel", i),  32'(rsel_err),  32'd0);
        if (e.mode == 0) begin
          chk($sformatf("v%0d_w7_n", i), 32'(w7.size()), 32'd2);
          if (w7.size() == 2) begin
            chk($sformatf("v%0d_w7_ph0", i), w7[0], 32'hA5A5_0007);
            chk($sformatf("v%0d_w7_ph1", i), w7[1], 32'h5A5A_FFF8);
          end
        end
      end
    end

    // Reset in the middle of a run: outputs clear asynchronously and nothing restarts.
    do_reset(0);
    @(negedge CLK);
    start = 1'b1;
    @(posedge CLK);
    #1;
    start = 1'b0;
    repeat (40) @(posedge CLK);
    #2;
    chk("midrun_busy_before", 32'(busy), 32'd1);
    nRST = 1'b0;
    #1;
    outs_zero("midrun");
    @(negedge CLK);
    nRST = 1'b1;
    n = 0;
    for (int c = 0; c < 200; c++) begin
      @(posedge CLK);
      #1;
      if (busy || done) n++;
    end
    chk("idle_after_reset", 32'(n), 32'd0);

    // Start held high: first run completes normally, DONE lasts two samples, then a new run begins.
    do_reset(0);
    @(negedge CLK);
    start = 1'b1;
    n = 0; first_done = 0; first_busy = 0;
    while (first_busy == 0 && n < 400) begin
      @(posedge CLK);
      #1;
      n++;
      if (done && first_done == 0) begin
        first_done = n;
        chk("hold_pass1", 32'(pass), 32'd1);
      end
      if (first_done != 0 && busy) first_busy = n;
    end
    chk("hold_lat", 32'(first_done - 1), 32'd129);
    chk("hold_done_len", 32'(first_busy - first_done), 32'd2);
    start = 1'b0;
    n = 0; got = 0;
    while (!got && n < 300) begin
      @(posedge CLK);
      #1;
      n++;
      if (done) got = 1;
    end
    chk("hold_second_done", 32'(got), 32'd1);
    chk("hold_second_lat", 32'(n), 32'd128);
    chk("hold_pass2", 32'(pass), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
